subpulse_decombiner: RTL and testbench

- Inverse of the factor-N sub-pulse combiner: recovers individual sub-pulse samples from a combined (running-sum) beam stream.
- Within a trigger-started train of N windows of L samples each: window 0 passes through; windows k≥1 output din(t) − din(t−L) using an L-deep delay line.
- Sits downstream of the ADC/combiner path on the FONT5A board (357 MHz) and feeds per-sub-pulse diagnostics.

---
 rtl/subpulse_decombiner.sv | 186 ++++++++++++++++++
 tb/tb_subpulse_decombiner.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/subpulse_decombiner.sv
// -----------------------------------------------------------------------------
// subpulse_decombiner
//   Undoes the factor-N sub-pulse combiner. A trigger starts a train of
//   COMB_FACT windows, each SUB_PULSE_LEN samples long. Window 0 is passed
//   through unchanged. Every later window outputs din(t) - din(t-L), which
//   strips the running sum back to the individual sub-pulse. The difference
//   saturates to 16 bits. All outputs are registered, so latency is one clock.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : signed combined-beam sample, one per clock
//   trig       : single-cycle train start; din on this cycle is sample 0
//   bypass     : 1 = pass din straight through in every window
//   dout       : signed recovered sample
//   dvalid     : dout carries a train sample
//   sub_idx    : window index of dout
//   sat        : dout was clamped on this output cycle
//   busy       : a train is in progress
//   retrig_err : one-cycle pulse, trig ignored because a train was running
// -----------------------------------------------------------------------------
module subpulse_decombiner #(
    parameter int SUB_PULSE_LEN = 100,
    parameter int COMB_FACT     = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [15:0]           din,
    input  logic                         trig,
    input  logic                         bypass,
    output logic signed [15:0]           dout,
    output logic                         dvalid,
    output logic [$clog2(COMB_FACT)-1:0] sub_idx,
    output logic                         sat,
    output logic                         busy,
    output logic                         retrig_err
);
    localparam int CNT_W = $clog2(SUB_PULSE_LEN);
    localparam int WIN_W = $clog2(COMB_FACT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SUB_PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COMB_FACT - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_DIFF  = 2'd2
    } state_t;

    // Clamp a 17-bit signed value to 16 bits; bit 16 of the result flags a clamp.
    function automatic logic [16:0] sat16(input logic signed [16:0] v);
        logic [16:0] res;
        if (v[16] != v[15]) begin
            res = v[16] ? {1'b1, 16'h8000} : {1'b1, 16'h7FFF};
        end else begin
            res = {1'b0, v[15:0]};
        end
        return res;
    endfunction

    logic signed [15:0] r_dl [SUB_PULSE_LEN];
    logic signed [15:0] w_tap;
    logic signed [16:0] w_diff;
    logic        [16:0] w_sat;
    logic               w_cnt_wrap;
    logic               w_last;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIN_W-1:0]   r_win;
    logic signed [15:0] r_dout;
    logic               r_dvalid;
    logic [WIN_W-1:0]   r_sub_idx;
    logic               r_sat;
    logic               r_busy;
    logic               r_retrig_err;

    // Delay line: free-running shift of din; contents need no reset because
    // the tap is only consumed once a full window has been loaded in the train.
    always_ff @(posedge clk) begin
        r_dl[0] <= din;
        for (int i = 1; i < SUB_PULSE_LEN; i++) begin
            r_dl[i] <= r_dl[i-1];
        end
    end

    assign w_tap      = r_dl[SUB_PULSE_LEN-1];
    assign w_diff     = {din[15], din} - {w_tap[15], w_tap};
    assign w_sat      = sat16(w_diff);
    assign w_cnt_wrap = (r_cnt == CNT_LAST);
    assign w_last     = w_cnt_wrap && (r_win == WIN_LAST);

    // Train FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_win        <= '0;
            r_dout       <= 16'sd0;
            r_dvalid     <= 1'b0;
            r_sub_idx    <= '0;
            r_sat        <= 1'b0;
            r_busy       <= 1'b0;
            r_retrig_err <= 1'b0;
        end else begin
            r_dout       <= 16'sd0;
            r_dvalid     <= 1'b0;
            r_sub_idx    <= '0;
            r_sat        <= 1'b0;
            r_retrig_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (trig) begin
                        // The trigger cycle's din is already sample 0.
                        r_dout   <= din;
                        r_dvalid <= 1'b1;
                        r_cnt    <= CNT_ONE;
                        r_win    <= '0;
                        r_state  <= ST_FIRST;
                        r_busy   <= 1'b1;
                    end else begin
                        r_busy   <= 1'b0;
                    end
                end
                ST_FIRST: begin
                    r_dout       <= din;
                    r_dvalid     <= 1'b1;
                    r_retrig_err <= trig;
                    if (w_cnt_wrap) begin
                        r_cnt   <= '0;
                        r_win   <= WIN_ONE;
                        r_state <= ST_DIFF;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                ST_DIFF: begin
                    r_dvalid  <= 1'b1;
                    r_sub_idx <= r_win;
                    if (bypass) begin
                        r_dout <= din;
                    end else begin
                        r_dout <= w_sat[15:0];
                        r_sat  <= w_sat[16];
                    end
                    if (w_last) begin
                        r_cnt <= '0;
                        r_win <= '0;
                        // A trigger on the final sample chains straight into
                        // the next train; the next din is its sample 0.
                        if (trig) begin
                            r_state <= ST_FIRST;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_retrig_err <= trig;
                        if (w_cnt_wrap) begin
                            r_cnt <= '0;
                            r_win <= r_win + WIN_ONE;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_win   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_dout;
    assign dvalid     = r_dvalid;
    assign sub_idx    = r_sub_idx;
    assign sat        = r_sat;
    assign busy       = r_busy;
    assign retrig_err = r_retrig_err;

endmodule

// File: tb/tb_subpulse_decombiner.sv
// -----------------------------------------------------------------------------
// tb_subpulse_decombiner
//   Drives two instances from shared inputs: a small one (L=4, N=4) for the
//   directed scenarios and one with default parameters (L=100, N=4) for a
//   long random train. Expected outputs come from a sample-position model:
//   each instance tracks which train sample (if any) is being processed and
//   the expected value is computed from the din history with integer math.
// -----------------------------------------------------------------------------
module tb_subpulse_decombiner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               trig;
    logic               bypass;
    logic signed [15:0] din;

    logic signed [15:0] s_dout, d_dout;
    logic               s_dv, d_dv, s_sat, d_sat, s_busy, d_busy, s_re, d_re;
    logic [1:0]         s_idx, d_idx;

    subpulse_decombiner #(.SUB_PULSE_LEN(4), .COMB_FACT(4)) u_s (
        .clk(clk), .rst_n(rst_n), .din(din), .trig(trig), .bypass(bypass),
        .dout(s_dout), .dvalid(s_dv), .sub_idx(s_idx), .sat(s_sat),
        .busy(s_busy), .retrig_err(s_re)
    );

    subpulse_decombiner u_d (
        .clk(clk), .rst_n(rst_n), .din(din), .trig(trig), .bypass(bypass),
        .dout(d_dout), .dvalid(d_dv), .sub_idx(d_idx), .sat(d_sat),
        .busy(d_busy), .retrig_err(d_re)
    );

    int total = 0;
    int bad   = 0;

    // model state, index 0 = small instance, 1 = default instance
    int lm[2] = '{4, 100};
    int nm[2] = '{4, 4};
    int pos[2] = '{-1, -1};
    int e_dout[2], e_dv[2], e_idx[2], e_sat[2], e_busy[2], e_re[2];
    int hist[$];

    // statistics gathered from the small instance (and dvalid of the big one)
    int n_dv, n_dvd, n_sat, n_re, sum_s;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_dv = 0; n_dvd = 0; n_sat = 0; n_re = 0; sum_s = 0;
    endtask

    // Expected outputs after the coming edge for instance m.
    task automatic model(input int m, input int d, input logic t,
                         input logic b, input logic r);
        int p, k, v, n, last;
        n    = hist.size();
        last = nm[m] * lm[m] - 1;
        e_dout[m] = 0; e_dv[m] = 0; e_idx[m] = 0; e_sat[m] = 0; e_re[m] = 0;
        if (!r) begin
            pos[m] = -1;
        end else begin
            p = -1;
            if (pos[m] < 0) begin
                if (t) p = 0;
            end else begin
                p = pos[m];
                if (t && p != last) e_re[m] = 1;
            end
            if (p >= 0) begin
                k = p / lm[m];
                e_dv[m]  = 1;
                e_idx[m] = k;
                if (k == 0 || b) begin
                    v = d;
                end else begin
                    v = d - hist[n - lm[m]];
                    if (v > 32767) begin
                        v = 32767; e_sat[m] = 1;
                    end else if (v < -32768) begin
                        v = -32768; e_sat[m] = 1;
                    end
                end
                e_dout[m] = v;
                if (p == last) pos[m] = t ? 0 : -1;
                else           pos[m] = p + 1;
            end
        end
        e_busy[m] = (pos[m] >= 0) ? 1 : 0;
    endtask

    task automatic cyc(input int d, input logic t, input logic b, input logic r);
        din = 16'(d); trig = t; bypass = b; rst_n = r;
        model(0, d, t, b, r);
        model(1, d, t, b, r);
        hist.push_back(d);
        @(posedge clk);
        #1;
        chk("s_dout",   $signed(s_dout),   e_dout[0]);
        chk("s_dvalid", {31'd0, s_dv},     e_dv[0]);
        chk("s_subidx", {30'd0, s_idx},    e_idx[0]);
        chk("s_sat",    {31'd0, s_sat},    e_sat[0]);
        chk("s_busy",   {31'd0, s_busy},   e_busy[0]);
        chk("s_retrig", {31'd0, s_re},     e_re[0]);
        chk("d_dout",   $signed(d_dout),   e_dout[1]);
        chk("d_dvalid", {31'd0, d_dv},     e_dv[1]);
        chk("d_subidx", {30'd0, d_idx},    e_idx[1]);
        chk("d_sat",    {31'd0, d_sat},    e_sat[1]);
        chk("d_busy",   {31'd0, d_busy},   e_busy[1]);
        chk("d_retrig", {31'd0, d_re},     e_re[1]);
        if (s_dv === 1'b1) begin
            n_dv++;
            sum_s += int'(s_dout);
        end
        if (s_sat === 1'b1) n_sat++;
        if (s_re === 1'b1)  n_re++;
        if (d_dv === 1'b1)  n_dvd++;
    endtask

    int sv[4] = '{-30000, 30000, 30000, -30000};

    initial begin
        // reset and idle
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cyc(7, 1'b0, 1'b0, 1'b1);

        // identity: running sums of x=[1,2,3,4]
        clr();
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                cyc((w + 1) * (j + 1), (w == 0 && j == 0), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b0, 1'b1);
        chk("id_dvcnt", n_dv, 16);
        chk("id_sum", sum_s, 40);
        chk("id_satcnt", n_sat, 0);

        // saturation both directions
        clr();
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                cyc(sv[w], (w == 0 && j == 0), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b1);
        chk("sat_cnt", n_sat, 8);

        // bypass: dout = din delayed one cycle
        clr();
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                cyc((w + 1) * (j + 1), (w == 0 && j == 0), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b1, 1'b1);
        chk("byp_sum", sum_s, 100);
        chk("byp_satcnt", n_sat, 0);

        // retrigger at sample 5 (ignored) and sample 15 (chained train)
        clr();
        for (int i = 0; i < 32; i++)
            cyc(int'($urandom_range(0, 2000)) - 1000, (i == 0 || i == 5 || i == 15), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b1);
        chk("rt_dvcnt", n_dv, 32);
        chk("rt_errcnt", n_re, 1);

        // reset mid-train, then a clean train
        for (int i = 0; i < 6; i++) cyc(100 + i, (i == 0), 1'b0, 1'b1);
        cyc(106, 1'b0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0, 1'b1);
        clr();
        for (int w = 0; w < 4; w++)
            for (int j = 0; j < 4; j++)
                cyc((w + 1) * (j + 1), (w == 0 && j == 0), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 1'b0, 1'b0, 1'b1);
        chk("rst_dvcnt", n_dv, 16);
        chk("rst_sum", sum_s, 40);

        // let the long instance drain
        for (int i = 0; i < 400; i++) cyc(int'($urandom_range(0, 200)), 1'b0, 1'b0, 1'b1);

        // default parameters: random full-range train, occasional bypass
        clr();
        for (int i = 0; i < 400; i++)
            cyc(int'($urandom_range(0, 65535)) - 32768, (i == 0),
                ($urandom_range(0, 7) == 0), 1'b1);
        for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b0, 1'b1);
        chk("dflt_dvcnt", n_dvd, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
